// File: rtl/and_or_sched.sv
// Round-robin scheduler sharing one (a & b) | c unit among N requesters; SETTLE+2 cycles per request.
// Requests wait (level-held) while busy; operands latched at grant, response is a one-cycle strobe.
module and_or_sched #(
    parameter int N      = 4,
    parameter int SETTLE = 2,
    parameter int CW     = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    input  logic [N-1:0] c_in,
    output logic [N-1:0] gnt,
    output logic [N-1:0] rsp_valid,
    output logic         rsp_y,
    output logic         busy,
    output logic         unit_a,
    output logic         unit_b,
    output logic         unit_c,
    input  logic         unit_y
);

    localparam int PW = $clog2(N);

    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    state_t        state, state_n;
    logic [PW-1:0] ptr, ptr_n;
    logic [PW-1:0] win_idx, win_idx_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [N-1:0]  gnt_n, rsp_valid_n;
    logic          rsp_y_n, busy_n;
    logic          unit_a_n, unit_b_n, unit_c_n;

    logic          found;
    logic [PW-1:0] win;
    logic [N-1:0]  win_oh;
    int            idx;

    // Search starts at ptr and wraps, so the first hit is the round-robin winner.
    always_comb begin
        found  = 1'b0;
        win    = '0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
        win_oh      = '0;
        win_oh[win] = 1'b1;
    end

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        win_idx_n   = win_idx;
        cnt_n       = cnt;
        gnt_n       = gnt;
        rsp_valid_n = rsp_valid;
        rsp_y_n     = rsp_y;
        unit_a_n    = unit_a;
        unit_b_n    = unit_b;
        unit_c_n    = unit_c;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_n     = win_oh;
                    win_idx_n = win;
                    unit_a_n  = a_in[win];
                    unit_b_n  = b_in[win];
                    unit_c_n  = c_in[win];
                    cnt_n     = CW'(SETTLE - 1);
                    state_n   = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    rsp_y_n     = unit_y;
                    rsp_valid_n = gnt;
                    state_n     = RESP;
                end
            end
            RESP: begin
                rsp_valid_n = '0;
                gnt_n       = '0;
                // Advance past the served requester even if it keeps requesting.
                ptr_n       = (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            win_idx   <= '0;
            cnt       <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_y     <= 1'b0;
            busy      <= 1'b0;
            unit_a    <= 1'b0;
            unit_b    <= 1'b0;
            unit_c    <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            win_idx   <= win_idx_n;
            cnt       <= cnt_n;
            gnt       <= gnt_n;
            rsp_valid <= rsp_valid_n;
            rsp_y     <= rsp_y_n;
            busy      <= busy_n;
            unit_a    <= unit_a_n;
            unit_b    <= unit_b_n;
            unit_c    <= unit_c_n;
        end
    end

endmodule

// File: tb/tb_and_or_sched.sv
// Directed plus randomized bench for and_or_sched against a request-level round-robin model.
module tb_and_or_sched;

    localparam int N      = 4;
    localparam int SETTLE = 2;
    localparam int CW     = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req, a_in, b_in, c_in;
    logic [N-1:0] gnt, rsp_valid;
    logic         rsp_y, busy, unit_a, unit_b, unit_c, unit_y;

    int n_assert = 0;
    int n_fail   = 0;
    int m_ptr    = 0;

    and_or_sched #(.N(N), .SETTLE(SETTLE), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .c_in      (c_in),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_y     (rsp_y),
        .busy      (busy),
        .unit_a    (unit_a),
        .unit_b    (unit_b),
        .unit_c    (unit_c),
        .unit_y    (unit_y)
    );

    // The shared evaluation unit the scheduler drives.
    assign unit_y = (unit_a & unit_b) | unit_c;

    always #5 clk = ~clk;

    task automatic check_v(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check_b("gnt_onehot0", $onehot0(gnt), 1'b1);
        check_b("rsp_valid_onehot0", $onehot0(rsp_valid), 1'b1);
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (p + k) % N;
            if (r[i]) return i;
        end
        return 0;
    endfunction

    // Called in an IDLE cycle with req already applied; post_* are applied after the grant.
    task automatic run_txn(input logic [N-1:0] post_req, input logic [N-1:0] post_a);
        int           w;
        logic         ea, eb, ec, ey;
        logic [N-1:0] oh;
        check_b("req_pending", |req, 1'b1);
        w  = pick(req, m_ptr);
        ea = a_in[w];
        eb = b_in[w];
        ec = c_in[w];
        ey = (ea & eb) | ec;
        oh = '0;
        oh[w] = 1'b1;
        step();
        req  = post_req;
        a_in = post_a;
        for (int k = 0; k < SETTLE; k++) begin
            check_v("gnt_drive", gnt, oh);
            check_v("rsp_valid_drive", rsp_valid, '0);
            check_b("busy_drive", busy, 1'b1);
            check_b("unit_a", unit_a, ea);
            check_b("unit_b", unit_b, eb);
            check_b("unit_c", unit_c, ec);
            step();
        end
        check_v("gnt_resp", gnt, oh);
        check_v("rsp_valid_resp", rsp_valid, oh);
        check_b("rsp_y", rsp_y, ey);
        check_b("busy_resp", busy, 1'b1);
        check_b("unit_a_resp", unit_a, ea);
        step();
        check_v("gnt_after", gnt, '0);
        check_v("rsp_valid_after", rsp_valid, '0);
        check_b("busy_after", busy, 1'b0);
        check_b("rsp_y_hold", rsp_y, ey);
        m_ptr = (w + 1) % N;
    endtask

    initial begin
        logic [2:0] abc;
        rst_n = 1'b0;
        req   = '0;
        a_in  = '0;
        b_in  = '0;
        c_in  = '0;
        step();
        step();
        check_v("rst_gnt", gnt, '0);
        check_v("rst_rsp_valid", rsp_valid, '0);
        check_b("rst_rsp_y", rsp_y, 1'b0);
        check_b("rst_busy", busy, 1'b0);
        check_v("rst_unit", N'({unit_a, unit_b, unit_c}), '0);
        rst_n = 1'b1;
        step();

        // Single request on requester 1, abc = 110.
        req  = 4'b0010;
        a_in = 4'b0010;
        b_in = 4'b0010;
        c_in = 4'b0000;
        run_txn(req, a_in);

        // Full truth table through requester 1.
        for (int v = 0; v < 8; v++) begin
            abc     = 3'(v);
            a_in    = '0;
            b_in    = '0;
            c_in    = '0;
            a_in[1] = abc[2];
            b_in[1] = abc[1];
            c_in[1] = abc[0];
            req     = 4'b0010;
            run_txn(req, a_in);
        end

        // Operands captured at grant; a_in[2] drops during DRIVE.
        req  = 4'b0100;
        a_in = 4'b0100;
        b_in = 4'b0100;
        c_in = 4'b0000;
        run_txn(req, 4'b0000);

        // Requester 0 withdraws after its grant; requester 1 is served next.
        req  = 4'b0011;
        a_in = N'($urandom);
        b_in = N'($urandom);
        c_in = N'($urandom);
        run_txn(4'b0010, a_in);
        run_txn(req, a_in);
        req = '0;
        step();

        // Reset while in DRIVE aborts the operation.
        req  = 4'b0001;
        a_in = 4'b1111;
        b_in = 4'b1111;
        c_in = 4'b1111;
        step();
        step();
        check_b("mid_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_v("mid_gnt", gnt, '0);
        check_v("mid_rsp_valid", rsp_valid, '0);
        check_b("mid_busy", busy, 1'b0);
        check_v("mid_unit", N'({unit_a, unit_b, unit_c}), '0);
        step();
        check_v("mid_rsp_valid_held", rsp_valid, '0);
        rst_n = 1'b1;
        m_ptr = 0;
        req   = 4'b1000;
        run_txn(req, a_in);

        // All requesters active: rotation 0,1,2,3,0 back to back.
        req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            a_in = N'($urandom);
            b_in = N'($urandom);
            c_in = N'($urandom);
            check_b("rr_model_order", m_ptr == (r % N), 1'b1);
            run_txn(req, a_in);
        end

        // Random request patterns and operands.
        for (int r = 0; r < 24; r++) begin
            req  = N'($urandom_range(1, (1 << N) - 1));
            a_in = N'($urandom);
            b_in = N'($urandom);
            c_in = N'($urandom);
            run_txn(req, a_in);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/and_or_sched.md
Name: and_or_sched

Overview:
- Round-robin scheduler that shares one combinational and/or evaluation unit (y = (a & b) | c) among N requesters.
- Serves one request at a time:
  - arbitrates among pending requests;
  - latches the winner's operands and drives them onto the shared unit;
  - holds them for a settle window, samples y;
  - returns y to the winner with a one-cycle valid pulse.
- Sits between the requesting blocks and the single shared and/or instance.

Parameters:
- N, 4, number of requesters (2..8).
- SETTLE, 2, cycles operands are held on the unit before y is sampled (>=1).
- CW, 3, width of settle counter; must satisfy 2^CW > SETTLE.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  per-requester request level.
- a_in  input  N  per-requester operand a.
- b_in  input  N  per-requester operand b.
- c_in  input  N  per-requester operand c.
- gnt  output  N  one-hot grant, registered.
- rsp_valid  output  N  one-hot one-cycle result strobe, registered.
- rsp_y  output  1  result bit, valid when any rsp_valid bit is high.
- busy  output  1  high in any state other than IDLE.
- unit_a  output  1  operand a to shared unit, registered.
- unit_b  output  1  operand b to shared unit, registered.
- unit_c  output  1  operand c to shared unit, registered.
- unit_y  input  1  result from shared unit.

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is asynchronous and active-low.
- Reset values:
  - State = IDLE.
  - gnt = 0, rsp_valid = 0, rsp_y = 0, busy = 0.
  - unit_a/b/c = 0.
  - Round-robin pointer ptr = 0, cnt = 0.
  - Reset asserted mid-operation aborts it immediately. No response is issued for the aborted request.
- FSM states: IDLE, DRIVE, RESP.
- IDLE:
  - If req == 0: stay in IDLE, outputs unchanged (gnt = 0).
  - Else select winner g = first index with req[g] = 1, searching ptr, ptr+1, ... mod N.
  - At the clock edge:
    - gnt <= onehot(g).
    - unit_a <= a_in[g], unit_b <= b_in[g], unit_c <= c_in[g].
    - cnt <= SETTLE-1.
    - State <= DRIVE.
  - Operands are captured only here. Later changes to a_in/b_in/c_in do not affect the operation in progress.
- DRIVE:
  - gnt and unit_* are held.
  - If cnt != 0: cnt decrements.
  - If cnt == 0: rsp_y <= unit_y, rsp_valid <= onehot(g), state <= RESP.
- RESP:
  - rsp_valid and rsp_y are visible for exactly this one cycle.
  - At the edge:
    - rsp_valid <= 0, gnt <= 0.
    - ptr <= (g+1) mod N.
    - State <= IDLE.
  - rsp_y holds its value until the next sample.
- busy is registered and equals (state != IDLE).
- Latency: req high in IDLE cycle t gives:
  - gnt high in cycles t+1 .. t+SETTLE+1;
  - rsp_valid high in cycle t+SETTLE+1;
  - earliest next grant in cycle t+SETTLE+3.
  - Per-request period is SETTLE+2 cycles.
- Fairness:
  - The pointer advances past the served requester even if that requester keeps req high.
  - With all requesters active, grants rotate 0, 1, ..., N-1, 0, ...
- Requester dropping req during DRIVE or RESP: the operation still completes and the response is still issued.
- New requests arriving while busy wait; they are arbitrated on the next IDLE cycle.
- Simultaneous requests: only the round-robin winner is served. The others stay pending. No request is lost as long as its req stays high.
- Never more than one gnt bit or one rsp_valid bit is high.

Test Plan:
- Reset then single request (N=4, SETTLE=2): req=0010 with a_in[1]=1, b_in[1]=1, c_in[1]=0 in cycle t.
  - Required: gnt=0010 in cycles t+1..t+3; unit_a/b/c=1/1/0.
  - Required: rsp_valid=0010 with rsp_y=1 in cycle t+3; busy low in t+4.
- Truth table through one requester: all 8 a/b/c combinations sequentially.
  - Required: rsp_y = 0,1,0,1,0,1,1,1 for abc = 000, 001, 010, 011, 100, 101, 110, 111.
- Round-robin with all four requesters held high.
  - Required: grant order 0, 1, 2, 3, 0; each grant SETTLE+2 = 4 cycles apart.
  - Required: never two gnt bits high at once.
- Operand change after capture: requester 2 with abc=110 granted, then a_in[2] set to 0 during DRIVE.
  - Required: rsp_y=1; unit_a stays 1.
- Reset mid-operation: assert rst_n=0 during DRIVE.
  - Required: gnt, rsp_valid, unit_* and busy go to 0 immediately.
  - Required: after release with req=1000, the first grant goes to requester 3.
- Requester withdraws: req[0] dropped the cycle after its grant.
  - Required: rsp_valid[0] still pulses at t+3.
  - Required: ptr advances, so the next pending request at index 1 is granted.
